// File: rtl/svm_pkg.sv
// Shared types and helpers for the SVM emotion-classification sequencer.
package svm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_V,
        ST_ISSUE_A,
        ST_WAIT_DONE,
        ST_RESULT
    } svm_seq_state_t;

    localparam logic MODEL_VALENCE = 1'b0;
    localparam logic MODEL_AROUSAL = 1'b1;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int ceilLog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 31; i++) begin
            if (v > 0) begin
                r++;
                v = v >>> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/svm_seq_watchdog.sv
// Clearable saturating cycle counter; flags expiry once LIMIT-1 is reached.
module svm_seq_watchdog #(
    parameter int LIMIT = 1024,
    parameter int W     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Only meaningful while the sequencer is actually waiting on the engine.
    assign expired = en && (count == LAST);

endmodule

// File: rtl/svm_sequencer.sv
// Runs one sample through the shared SVM engine: valence issue, arousal issue, collect.
// Optional watchdog enabled by defining SVM_SEQ_TIMEOUT_EN.
module svm_sequencer
    import svm_pkg::*;
#(
    parameter int NBITS       = 5,
    parameter int F_WIDTH     = 1,
    parameter int TIMEOUT     = 1024,
    parameter int LOG_TIMEOUT = ceilLog2(TIMEOUT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [NBITS*F_WIDTH-1:0]   in_features,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic signed [NBITS*F_WIDTH-1:0]   eng_features,
    output logic                              model_sel,
    output logic                              eng_valid,
    input  logic                              eng_ready,
    input  logic                              eng_dout_valid,
    input  logic                              eng_valence,
    input  logic                              eng_arousal,
    output logic                              eng_flush,
    output logic                              out_valence,
    output logic                              out_arousal,
    output logic                              out_error,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy
);

    svm_seq_state_t state, state_nxt;

    logic accept;
    logic valence_hs;
    logic capture;
    logic timeout_hit;
    logic wd_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        valence_hs  = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        in_ready    = 1'b0;
        eng_valid   = 1'b0;
        out_valid   = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Reset has priority over a sample offered in the same cycle.
                in_ready = !rst;
                if (in_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE_V;
                end
            end
            ST_ISSUE_V: begin
                eng_valid = 1'b1;
                if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_RESULT;
                end else if (eng_ready) begin
                    valence_hs = 1'b1;
                    state_nxt  = ST_ISSUE_A;
                end
            end
            ST_ISSUE_A: begin
                eng_valid = 1'b1;
                if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_RESULT;
                end else if (eng_ready) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A real answer beats a watchdog expiry in the same cycle.
                if (eng_dout_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESULT;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_RESULT;
                end
            end
            ST_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bank select flips only on handshake edges so the parameter mux is stable under eng_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_features <= '0;
            model_sel    <= MODEL_VALENCE;
            out_valence  <= 1'b0;
            out_arousal  <= 1'b0;
        end else begin
            if (accept) begin
                eng_features <= in_features;
                model_sel    <= MODEL_VALENCE;
            end else if (valence_hs) begin
                model_sel <= MODEL_AROUSAL;
            end
            if (capture) begin
                out_valence <= eng_valence;
                out_arousal <= eng_arousal;
            end else if (timeout_hit) begin
                out_valence <= 1'b0;
                out_arousal <= 1'b0;
            end
        end
    end

`ifdef SVM_SEQ_TIMEOUT_EN
    logic wd_en;

    assign wd_en = (state == ST_ISSUE_V) || (state == ST_ISSUE_A) || (state == ST_WAIT_DONE);

    svm_seq_watchdog #(
        .LIMIT (TIMEOUT),
        .W     (LOG_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_flush <= 1'b0;
            out_error <= 1'b0;
        end else begin
            eng_flush <= timeout_hit;
            if (capture) begin
                out_error <= 1'b0;
            end else if (timeout_hit) begin
                out_error <= 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign eng_flush  = 1'b0;
    assign out_error  = 1'b0;
`endif

endmodule

// File: tb/tb_svm_sequencer.sv
// Scoreboard bench for svm_sequencer: directed samples, queued expectations, decoupled monitor.
module tb_svm_sequencer;

    localparam int NBITS   = 5;
    localparam int F_WIDTH = 1;
    localparam int TMO     = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic signed [NBITS-1:0]   in_features;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [NBITS-1:0]   eng_features;
    logic                      model_sel;
    logic                      eng_valid;
    logic                      eng_ready;
    logic                      eng_dout_valid;
    logic                      eng_valence;
    logic                      eng_arousal;
    logic                      eng_flush;
    logic                      out_valence;
    logic                      out_arousal;
    logic                      out_error;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;

    svm_sequencer #(
        .NBITS   (NBITS),
        .F_WIDTH (F_WIDTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_features    (in_features),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .eng_features   (eng_features),
        .model_sel      (model_sel),
        .eng_valid      (eng_valid),
        .eng_ready      (eng_ready),
        .eng_dout_valid (eng_dout_valid),
        .eng_valence    (eng_valence),
        .eng_arousal    (eng_arousal),
        .eng_flush      (eng_flush),
        .out_valence    (out_valence),
        .out_arousal    (out_arousal),
        .out_error      (out_error),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             sel;
        logic [NBITS-1:0] feat;
    } issue_t;

    issue_t     issue_q[$];
    logic [2:0] res_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int flush_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_issue(input logic [NBITS-1:0] f);
        issue_q.push_back({1'b0, f});
        issue_q.push_back({1'b1, f});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations on every engine issue and every result handshake.
    initial forever begin
        issue_t     e;
        logic [2:0] r;
        @(negedge clk);
        if (rst !== 1'b0) continue;
        if (eng_flush) flush_cnt++;
        if (eng_valid && eng_ready) begin
            if (issue_q.size() == 0) begin
                check("extra_issue", 32'd1, 32'd0);
            end else begin
                e = issue_q.pop_front();
                check("issue_sel", {31'd0, model_sel}, {31'd0, e.sel});
                check("issue_feat", {27'd0, $unsigned(eng_features)}, {27'd0, e.feat});
            end
        end
        if (out_valid && out_ready) begin
            if (res_q.size() == 0) begin
                check("extra_result", 32'd1, 32'd0);
            end else begin
                r = res_q.pop_front();
                check("result_word", {29'd0, out_valence, out_arousal, out_error}, {29'd0, r});
            end
        end
    end

    task automatic accept(input logic signed [NBITS-1:0] f);
        in_features = f;
        in_valid    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                step();
                in_valid    = 1'b0;
                in_features = ~f;
                return;
            end
            step();
        end
        check("accept_seen", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_arousal_issue();
        for (int i = 0; i < 100; i++) begin
            if (eng_valid && eng_ready && model_sel) begin
                step();
                return;
            end
            step();
        end
        check("arousal_issue_seen", 32'd0, 32'd1);
    endtask

    task automatic engine_pulse(input logic v, input logic a);
        eng_dout_valid = 1'b1;
        eng_valence    = v;
        eng_arousal    = a;
        step();
        eng_dout_valid = 1'b0;
        eng_valence    = 1'b0;
        eng_arousal    = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (out_valid && out_ready) begin
                step();
                return;
            end
            step();
        end
        check("result_seen", 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        int t1;
        rst            = 1'b1;
        in_valid       = 1'b1;
        in_features    = 5'sd5;
        eng_ready      = 1'b0;
        eng_dout_valid = 1'b0;
        eng_valence    = 1'b0;
        eng_arousal    = 1'b0;
        out_ready      = 1'b1;

        // Reset with a sample offered: reset wins.
        repeat (3) step();
        #3;
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_eng_valid", {31'd0, eng_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_model_sel", {31'd0, model_sel}, 32'd0);
        check("rst_eng_flush", {31'd0, eng_flush}, 32'd0);
        check("rst_out_error", {31'd0, out_error}, 32'd0);
        check("rst_features",  {27'd0, $unsigned(eng_features)}, 32'd0);
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        #3;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy",     {31'd0, busy},     32'd0);
        step();

        // Basic run, 300-cycle engine latency, valence=1 arousal=0.
        eng_ready = 1'b1;
        push_issue(5'sd7);
        res_q.push_back(3'b100);
        accept(5'sd7);
        check("t1_issue_v_valid", {31'd0, eng_valid}, 32'd1);
        check("t1_issue_v_sel",   {31'd0, model_sel}, 32'd0);
        wait_arousal_issue();
        repeat (299) step();
        engine_pulse(1'b1, 1'b0);
        check("t1_out_valid_next", {31'd0, out_valid}, 32'd1);
        wait_result(5);
        check("t1_issue_q_empty", issue_q.size(), 32'd0);
        check("t1_res_q_empty",   res_q.size(),   32'd0);

        // Engine stalls the valence issue for 5 cycles.
        eng_ready = 1'b0;
        push_issue(-5'sd3);
        res_q.push_back(3'b010);
        accept(-5'sd3);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'd0, eng_valid}, 32'd1);
            check("t2_hold_sel",   {31'd0, model_sel}, 32'd0);
            check("t2_hold_feat",  {27'd0, $unsigned(eng_features)}, 32'h1d);
            step();
        end
        check("t2_no_early_issue", issue_q.size(), 32'd2);
        eng_ready = 1'b1;
        wait_arousal_issue();
        repeat (3) step();
        engine_pulse(1'b0, 1'b1);
        wait_result(5);

        // Result back-pressure with a pending sample (most negative feature).
        push_issue(-5'sd16);
        res_q.push_back(3'b110);
        accept(-5'sd16);
        wait_arousal_issue();
        step();
        out_ready = 1'b0;
        engine_pulse(1'b1, 1'b1);
        push_issue(5'sd15);
        in_features = 5'sd15;
        in_valid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid",    {31'd0, out_valid},   32'd1);
            check("t3_hold_valence",  {31'd0, out_valence}, 32'd1);
            check("t3_hold_arousal",  {31'd0, out_arousal}, 32'd1);
            check("t3_hold_in_ready", {31'd0, in_ready},    32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t3_idle_in_ready", {31'd0, in_ready},  32'd1);
        check("t3_idle_no_issue", {31'd0, eng_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        check("t3_accept_valid", {31'd0, eng_valid}, 32'd1);
        check("t3_accept_sel",   {31'd0, model_sel}, 32'd0);
        check("t3_accept_feat",  {27'd0, $unsigned(eng_features)}, 32'h0f);

        // Reset while waiting on the engine, then a late answer.
        wait_arousal_issue();
        step();
        check("t4_busy_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        engine_pulse(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t4_no_out_valid", {31'd0, out_valid}, 32'd0);
            check("t4_idle_busy",    {31'd0, busy},      32'd0);
            step();
        end

        // Spurious engine answer in IDLE.
        eng_dout_valid = 1'b1;
        eng_valence    = 1'b1;
        eng_arousal    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_spur_busy",      {31'd0, busy},      32'd0);
            check("t5_spur_out_valid", {31'd0, out_valid}, 32'd0);
        end
        eng_dout_valid = 1'b0;
        eng_valence    = 1'b0;
        check("t5_spur_no_capture", {31'd0, out_valence}, 32'd0);
        push_issue(5'sd1);
        res_q.push_back(3'b000);
        accept(5'sd1);
        wait_arousal_issue();
        step();
        engine_pulse(1'b0, 1'b0);
        wait_result(5);

`ifdef SVM_SEQ_TIMEOUT_EN
        // Engine never answers: watchdog forces an error result.
        flush_cnt = 0;
        push_issue(5'sd4);
        res_q.push_back(3'b001);
        accept(5'sd4);
        t0 = cyc;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) break;
            step();
        end
        t1 = cyc;
        check("t6_timeout_latency", t1 - t0, TMO);
        check("t6_flush_now", {31'd0, eng_flush}, 32'd1);
        check("t6_error",     {31'd0, out_error}, 32'd1);
        wait_result(5);
        repeat (3) step();
        check("t6_flush_once", flush_cnt, 32'd1);
`else
        t0 = 0;
        t1 = 0;
`endif

        repeat (2) step();
        check("end_issue_q_empty", issue_q.size(), 32'd0);
        check("end_res_q_empty",   res_q.size(),   32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svm_sequencer.md
# svm_sequencer

Sequences one emotion-classification sample through the shared `SVM` engine. It accepts a feature vector over a valid/ready handshake and issues two back-to-back engine transactions: valence model first, then arousal model. `model_sel` steers the top-level parameter-bank mux that feeds the engine's `in_support`, `in_alpha` and `in_intercept`. The block collects both decisions and presents them as one result word. It sits between the sensor-fusion front end and the `SVM` instance.

## Interface
Parameters:
- `NBITS`, 5, feature quantization width
- `F_WIDTH`, 1, number of features per sample
- `TIMEOUT`, 1024, watchdog limit in cycles (used only with `SVM_SEQ_TIMEOUT_EN`)
- `LOG_TIMEOUT`, `ceilLog2(TIMEOUT)`, watchdog counter width

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_features` in NBITS*F_WIDTH: sample features, signed.
- `in_valid` in 1 / `in_ready` out 1: sample handshake.
- `eng_features` out NBITS*F_WIDTH: registered copy of the accepted features, to engine `in_features`.
- `model_sel` out 1: 0 = valence bank, 1 = arousal bank.
- `eng_valid` out 1 / `eng_ready` in 1: to engine `fin_valid` / `fin_ready`.
- `eng_dout_valid` in 1, `eng_valence` in 1, `eng_arousal` in 1: engine results.
- `eng_flush` out 1: one-cycle pulse; the top ORs it into engine reset.
- `out_valence`, `out_arousal`, `out_error` out 1 each: result.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE_V, ISSUE_A, WAIT_DONE, RESULT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, register the features into `eng_features` and go to ISSUE_V.
- ISSUE_V:
  - `eng_valid`=1, `model_sel`=0.
  - On `eng_ready`, go to ISSUE_A.
- ISSUE_A:
  - `eng_valid`=1, `model_sel`=1.
  - On `eng_ready`, go to WAIT_DONE.
  - `model_sel` changes only on a handshake edge, so the bank mux is stable while `eng_valid` is high.
- WAIT_DONE:
  - `eng_valid`=0, `model_sel` holds 1.
  - On `eng_dout_valid`, capture `eng_valence` and `eng_arousal` into the `out_` registers, clear `out_error`, go to RESULT.
- RESULT:
  - `out_valid`=1, outputs held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in this state (no overlap).
- `eng_dout_valid` seen in any state other than WAIT_DONE is ignored.
- `eng_features` and `model_sel` do not change while `eng_valid`=1 and `eng_ready`=0.
- `in_features` is sampled only on the accepting edge. Later changes have no effect.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first post-reset cycle (IDLE).
  - `eng_valid`, `model_sel`, `eng_flush`, `out_valid`, `out_valence`, `out_arousal`, `out_error`, `busy` = 0.
  - `eng_features` = 0.
  - State = IDLE.
- Sample accepted at edge N → `eng_valid`=1 with `model_sel`=0 in cycle N+1.
- Valence handshake at edge M → `model_sel`=1 in cycle M+1.
- `eng_dout_valid` sampled at edge K → `out_valid`=1 in cycle K+1.
- Sequencer overhead: 3 cycles beyond engine latency.
- Reset in mid-operation: state returns to IDLE and the partial result is discarded. `eng_flush` is not pulsed, because the engine shares `rst`.
- `in_valid` and `rst` asserted in the same cycle: reset wins and the sample is not accepted.

## Configuration
- `SVM_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to ISSUE_V and increments each cycle in ISSUE_V, ISSUE_A and WAIT_DONE.
  - When the count reaches TIMEOUT-1 without a completing event, the block goes to RESULT with `out_error`=1, `out_valence`=0, `out_arousal`=0, and pulses `eng_flush` for one cycle.
  - If `eng_dout_valid` arrives in the same cycle as expiry, the valid result wins and `out_error`=0.
- `SVM_SEQ_TIMEOUT_EN` undefined: no counter, `out_error` and `eng_flush` are tied to 0, and the block waits indefinitely.

## Structure
- `svm_pkg` holds:
  - the state enum `svm_seq_state_t`;
  - constants `MODEL_VALENCE`=1'b0 and `MODEL_AROUSAL`=1'b1;
  - `ceilLog2` from `const.vh`.
- One sub-module, `svm_seq_watchdog`: a clearable saturating counter with an `expired` output. It is instantiated only under `SVM_SEQ_TIMEOUT_EN`.

## Test plan
- Features 5'sd7, `eng_ready` always 1, engine model returns valence=1, arousal=0 after 300 cycles → exactly two `eng_valid` handshakes with `model_sel` 0 then 1, then one result {1,0,err 0}.
- `eng_ready` held low for 5 cycles in ISSUE_V → `eng_valid`, `model_sel`=0 and `eng_features` stable throughout; no second issue before the handshake.
- `out_ready` low for 10 cycles in RESULT → outputs held, `in_ready`=0, a pending `in_valid` is not accepted; accepted in the cycle after `out_ready`.
- With `SVM_SEQ_TIMEOUT_EN`, TIMEOUT=64, engine never answers → `out_valid` with `out_error`=1 exactly 64 cycles after entering ISSUE_V, and one `eng_flush` pulse.
- `rst` asserted in WAIT_DONE, then a late `eng_dout_valid` → stays in IDLE, no `out_valid`.
- Spurious `eng_dout_valid` in IDLE → ignored, `busy`=0.
